// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encoding and
// default sizing of the multiply latency and stall-statistics counter.
package pipe_stall_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

    localparam int MUL_LATENCY_DEF = 4;
    localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: holds the front end while a multi-cycle
// multiply occupies EX, resolves branch flushes and load-use stalls, and
// counts cycles in which the PC is frozen.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             load_use_hazard,
    input  logic             mul_in_ex,
    input  logic             branch_taken,
    output logic             mul_start,
    output logic             mul_done,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             id_ex_enable,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // cnt reaches this value in the cycle the multiplier result is valid
    localparam logic [3:0] LAST_CNT = 4'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           next_state_s;
    logic [3:0]       cnt_r;
    logic [3:0]       next_cnt_s;
    logic [CNT_W-1:0] stall_cycles_r;

    // front-end decode shared by the done cycle and plain IDLE cycles
    logic fe_pc_en_s;
    logic fe_if_id_en_s;
    logic fe_id_ex_en_s;
    logic fe_flush_s;
    logic fe_bubble_s;

    // Front-end decode: a taken branch wins over a load-use stall
    always_comb begin
        fe_pc_en_s    = 1'b1;
        fe_if_id_en_s = 1'b1;
        fe_id_ex_en_s = 1'b1;
        fe_flush_s    = 1'b0;
        fe_bubble_s   = 1'b0;
        if (branch_taken) begin
            fe_flush_s  = 1'b1;
            fe_bubble_s = 1'b1;
        end else if (load_use_hazard) begin
            fe_pc_en_s    = 1'b0;
            fe_if_id_en_s = 1'b0;
            fe_bubble_s   = 1'b1;
        end else begin
            fe_flush_s  = 1'b0;
            fe_bubble_s = 1'b0;
        end
    end

    // Next-state and output decode from state, cycle counter and inputs
    always_comb begin
        next_state_s  = state_r;
        next_cnt_s    = cnt_r;
        mul_start     = 1'b0;
        mul_done      = 1'b0;
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        id_ex_enable  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mul_in_ex) begin
                    // start cycle: hazards are ignored, the whole front end holds
                    mul_start     = 1'b1;
                    pc_enable     = 1'b0;
                    if_id_enable  = 1'b0;
                    id_ex_enable  = 1'b0;
                    ex_mem_bubble = 1'b1;
                    next_state_s  = ST_MUL_BUSY;
                    next_cnt_s    = 4'd1;
                end else begin
                    pc_enable    = fe_pc_en_s;
                    if_id_enable = fe_if_id_en_s;
                    id_ex_enable = fe_id_ex_en_s;
                    if_id_flush  = fe_flush_s;
                    id_ex_bubble = fe_bubble_s;
                    next_cnt_s   = 4'd0;
                end
            end
            ST_MUL_BUSY: begin
                if (cnt_r == LAST_CNT) begin
                    mul_done     = 1'b1;
                    pc_enable    = fe_pc_en_s;
                    if_id_enable = fe_if_id_en_s;
                    id_ex_enable = fe_id_ex_en_s;
                    if_id_flush  = fe_flush_s;
                    id_ex_bubble = fe_bubble_s;
                    next_state_s = ST_IDLE;
                    next_cnt_s   = 4'd0;
                end else begin
                    pc_enable     = 1'b0;
                    if_id_enable  = 1'b0;
                    id_ex_enable  = 1'b0;
                    ex_mem_bubble = 1'b1;
                    next_cnt_s    = cnt_r + 4'd1;
                end
            end
            default: begin
                // unreachable encoding: recover to IDLE
                next_state_s = ST_IDLE;
                next_cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM state and multiply cycle counter
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (!pc_enable && (stall_cycles_r != STALL_MAX)) begin
            stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign busy         = (state_r == ST_MUL_BUSY);
    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model that tracks "EX cycles left in the current multiply".
module tb_pipe_stall_ctrl;

    localparam int LAT   = 4;
    localparam int CW    = 5;
    localparam int SMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          load_use_hazard = 1'b0;
    logic          mul_in_ex = 1'b0;
    logic          branch_taken = 1'b0;
    logic          mul_start, mul_done, pc_enable, if_id_enable, id_ex_enable;
    logic          if_id_flush, id_ex_bubble, ex_mem_bubble, busy;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // behavioural model: remaining EX cycles after this one, and stall total
    int m_left = 0;
    int m_stall = 0;
    int n_left = 0;
    int n_stall = 0;

    pipe_stall_ctrl #(.MUL_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .arst_n(arst_n), .load_use_hazard(load_use_hazard),
        .mul_in_ex(mul_in_ex), .branch_taken(branch_taken),
        .mul_start(mul_start), .mul_done(mul_done), .pc_enable(pc_enable),
        .if_id_enable(if_id_enable), .id_ex_enable(id_ex_enable),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .ex_mem_bubble(ex_mem_bubble), .busy(busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model reset takes effect immediately, like the DUT
    always @(negedge arst_n) begin
        m_left  = 0;
        m_stall = 0;
    end

    // model advance on the active edge, using decisions made mid-cycle
    always @(posedge clk) begin
        if (arst_n) begin
            m_left  = n_left;
            m_stall = n_stall;
        end else begin
            m_left  = 0;
            m_stall = 0;
        end
    end

    // compare process: inputs are stable at the falling edge
    always @(negedge clk) begin
        logic e_start, e_done, e_pc, e_ifid, e_idex, e_flush, e_bub, e_exb, e_busy;
        logic front;
        e_start = 1'b0; e_done = 1'b0; e_pc = 1'b1; e_ifid = 1'b1; e_idex = 1'b1;
        e_flush = 1'b0; e_bub = 1'b0; e_exb = 1'b0;
        e_busy  = (m_left > 0);
        front   = 1'b0;
        if (m_left == 0 && mul_in_ex) begin
            e_start = 1'b1; e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exb = 1'b1;
            n_left  = LAT - 1;
        end else if (m_left == 0) begin
            front  = 1'b1;
            n_left = 0;
        end else if (m_left == 1) begin
            e_done = 1'b1;
            front  = 1'b1;
            n_left = 0;
        end else begin
            e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exb = 1'b1;
            n_left = m_left - 1;
        end
        if (front && branch_taken) begin
            e_flush = 1'b1; e_bub = 1'b1;
        end else if (front && load_use_hazard) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1;
        end
        n_stall = (!e_pc && m_stall < SMAX) ? m_stall + 1 : m_stall;
        chk("mul_start", int'(mul_start), int'(e_start));
        chk("mul_done", int'(mul_done), int'(e_done));
        chk("pc_enable", int'(pc_enable), int'(e_pc));
        chk("if_id_enable", int'(if_id_enable), int'(e_ifid));
        chk("id_ex_enable", int'(id_ex_enable), int'(e_idex));
        chk("if_id_flush", int'(if_id_flush), int'(e_flush));
        chk("id_ex_bubble", int'(id_ex_bubble), int'(e_bub));
        chk("ex_mem_bubble", int'(ex_mem_bubble), int'(e_exb));
        chk("busy", int'(busy), int'(e_busy));
        chk("stall_cycles", int'(stall_cycles), m_stall);
    end

    // start a cycle: wait for the active edge, then drive inputs
    task automatic drive(input logic mul, input logic lu, input logic br);
        @(posedge clk);
        #1;
        mul_in_ex       = mul;
        load_use_hazard = lu;
        branch_taken    = br;
        #3;
    endtask

    initial begin
        int starts, dones, ex_cycles;
        // reset and idle decode
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        #3;
        chk("rst_pc_enable", int'(pc_enable), 1);
        chk("rst_id_ex_enable", int'(id_ex_enable), 1);
        chk("rst_flush", int'(if_id_flush), 0);
        chk("rst_ex_mem_bubble", int'(ex_mem_bubble), 0);
        chk("rst_stall", int'(stall_cycles), 0);

        // single multiply with mul_in_ex held
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk("dir_mul_start", int'(mul_start), (c == 0) ? 1 : 0);
            chk("dir_mul_done", int'(mul_done), (c == 3) ? 1 : 0);
            chk("dir_pc_enable", int'(pc_enable), (c == 3) ? 1 : 0);
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("dir_stall_after_mul", int'(stall_cycles), 3);

        // load-use stall in IDLE
        drive(1'b0, 1'b1, 1'b0);
        chk("lu_pc_enable", int'(pc_enable), 0);
        chk("lu_if_id_enable", int'(if_id_enable), 0);
        chk("lu_id_ex_bubble", int'(id_ex_bubble), 1);
        drive(1'b0, 1'b0, 1'b0);
        chk("lu_stall", int'(stall_cycles), 4);

        // branch beats load-use
        drive(1'b0, 1'b1, 1'b1);
        chk("br_flush", int'(if_id_flush), 1);
        chk("br_bubble", int'(id_ex_bubble), 1);
        chk("br_pc_enable", int'(pc_enable), 1);
        drive(1'b0, 1'b0, 1'b0);
        chk("br_stall", int'(stall_cycles), 4);

        // reset at cnt=2 abandons the multiply
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("pre_rst_busy", int'(busy), 1);
        arst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(mul_done), 0);
        chk("midrst_stall", int'(stall_cycles), 0);
        drive(1'b0, 1'b0, 1'b0);
        arst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("postrst_done", int'(mul_done), 0);
        chk("postrst_busy", int'(busy), 0);

        // back-to-back multiplies
        starts = 0; dones = 0; ex_cycles = 0;
        for (int c = 0; c < 10; c++) begin
            drive((c < 8) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            starts    += int'(mul_start);
            dones     += int'(mul_done);
            ex_cycles += int'(mul_start | busy);
        end
        chk("b2b_starts", starts, 2);
        chk("b2b_dones", dones, 2);
        chk("b2b_ex_cycles", ex_cycles, 8);
        chk("b2b_stall", int'(stall_cycles), 6);

        // saturation: hold load-use long enough to pass the counter maximum
        for (int c = 0; c < 40; c++) drive(1'b0, 1'b1, 1'b0);
        chk("sat_stall", int'(stall_cycles), SMAX);

        // randomized traffic with occasional asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 199) == 0) begin
                arst_n = 1'b0;
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
                arst_n = 1'b1;
            end
        end

        @(posedge clk);
        #6;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
